// File: rtl/nic8_sequencer.sv
// nic8_sequencer -- fetch/execute sequencer for the nic8 CPU.
//
// Owns the program counter (pc) and the instruction register (ir). It alternates
// FETCH and EXEC phases and steps the pc over ROM immediates. It applies taken jumps,
// detects a jump-to-self as a halt, and offers a single-step handshake for the
// debug front panel.
//
// Optional build macro: SEQ_BREAKPOINT_EN adds breakAddr/breakEn. A fetch from
// breakAddr (with breakEn=1) makes the sequencer park in WAIT after that
// instruction's EXEC, unless the instruction halts.
//
// Ports:
//   clk         in   system clock, rising-edge
//   reset       in   synchronous active-high reset, highest priority
//   romData     in   ROM read data at romAddr
//   busData     in   datapath bus; jump target during EXEC
//   doJumpBar   in   low = jump taken this EXEC
//   stepMode    in   1 = pause in WAIT after every instruction
//   stepReq     in   level request to run one instruction from WAIT
//   breakAddr   in   breakpoint address         (SEQ_BREAKPOINT_EN only)
//   breakEn     in   breakpoint enable          (SEQ_BREAKPOINT_EN only)
//   romAddr     out  ROM address, equal to pc (combinational)
//   ir          out  instruction register to the decoder
//   exec        out  high only in EXEC
//   halted      out  high in HALT
//   stepAck     out  one-cycle pulse after leaving WAIT on stepReq
//   instrCount  out  retired-instruction counter (wraps)

module nic8_sequencer #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        romData,
  input  logic [7:0]        busData,
  input  logic              doJumpBar,
  input  logic              stepMode,
  input  logic              stepReq,
`ifdef SEQ_BREAKPOINT_EN
  input  logic [ADDR_W-1:0] breakAddr,
  input  logic              breakEn,
`endif
  output logic [ADDR_W-1:0] romAddr,
  output logic [7:0]        ir,
  output logic              exec,
  output logic              halted,
  output logic              stepAck,
  output logic [CNT_W-1:0]  instrCount
);

  typedef enum logic [1:0] {
    StFetch,
    StExec,
    StWait,
    StHalt
  } state_e;

  // Low three opcode bits selecting the ROM (immediate) source.
  localparam logic [2:0] SrcRom = 3'b001;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic [ADDR_W-1:0]   instr_addr_q, instr_addr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                step_ack_q, step_ack_d;

  logic [ADDR_W-1:0]   jump_target;
  logic                halt_hit;
  logic                brk_wait;

  // Jump target is the bus value resized to the pc width.
  assign jump_target = ADDR_W'(busData);

  // A taken jump back to the address of the instruction being executed
  // would loop forever; treat it as a halt.
  assign halt_hit = !doJumpBar && (jump_target == instr_addr_q);

`ifdef SEQ_BREAKPOINT_EN
  logic brk_pend_q, brk_pend_d;
  assign brk_wait = brk_pend_q;
`else
  assign brk_wait = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    instr_addr_d = instr_addr_q;
    count_d      = count_q;
    step_ack_d   = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
    brk_pend_d   = brk_pend_q;
`endif

    unique case (state_q)
      StFetch: begin
        ir_d         = romData;
        instr_addr_d = pc_q;
        pc_d         = pc_q + 1'b1;
        state_d      = StExec;
`ifdef SEQ_BREAKPOINT_EN
        brk_pend_d   = breakEn && (pc_q == breakAddr);
`endif
      end

      StExec: begin
        // Jump overrides the immediate-operand step.
        if (!doJumpBar) begin
          pc_d = jump_target;
        end else if (ir_q[2:0] == SrcRom) begin
          pc_d = pc_q + 1'b1;
        end
        count_d = count_q + 1'b1;

        if (halt_hit) begin
          state_d = StHalt;
        end else if (stepMode || brk_wait) begin
          state_d = StWait;
        end else begin
          state_d = StFetch;
        end
`ifdef SEQ_BREAKPOINT_EN
        brk_pend_d = 1'b0;
`endif
      end

      StWait: begin
        // Leaving WAIT consumes the request, so a held stepReq still gives
        // one instruction per WAIT visit.
        if (stepReq) begin
          state_d    = StFetch;
          step_ack_d = 1'b1;
        end else if (!stepMode) begin
          state_d = StFetch;
        end
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      ir_q         <= 8'h00;
      instr_addr_q <= RESET_PC;
      count_q      <= '0;
      step_ack_q   <= 1'b0;
`ifdef SEQ_BREAKPOINT_EN
      brk_pend_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      instr_addr_q <= instr_addr_d;
      count_q      <= count_d;
      step_ack_q   <= step_ack_d;
`ifdef SEQ_BREAKPOINT_EN
      brk_pend_q   <= brk_pend_d;
`endif
    end
  end

  assign romAddr    = pc_q;
  assign ir         = ir_q;
  assign exec       = (state_q == StExec);
  assign halted     = (state_q == StHalt);
  assign stepAck    = step_ack_q;
  assign instrCount = count_q;

endmodule

// File: tb/tb_nic8_sequencer.sv
// Directed self-checking bench for nic8_sequencer (default build, no breakpoint).
// The ROM is modelled as an asynchronous array indexed by romAddr; the decoder
// is replaced by direct drive of doJumpBar/busData.

module tb_nic8_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  rom_data;
  logic [7:0]  bus_data;
  logic        do_jump_bar;
  logic        step_mode;
  logic        step_req;
  logic [7:0]  rom_addr;
  logic [7:0]  ir;
  logic        exec;
  logic        halted;
  logic        step_ack;
  logic [15:0] instr_count;

  logic [7:0]  rom [256];

  int n_checks;
  int n_fail;

  assign rom_data = rom[rom_addr];

  nic8_sequencer #(
    .ADDR_W  (8),
    .RESET_PC(8'h00),
    .CNT_W   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .romData   (rom_data),
    .busData   (bus_data),
    .doJumpBar (do_jump_bar),
    .stepMode  (step_mode),
    .stepReq   (step_req),
    .romAddr   (rom_addr),
    .ir        (ir),
    .exec      (exec),
    .halted    (halted),
    .stepAck   (step_ack),
    .instrCount(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one full cycle; always returns at a falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    do_jump_bar = 1'b1;
    step_mode   = 1'b0;
    step_req    = 1'b0;
    reset       = 1'b1;
    tick();
    tick();
    n_checks++;
    if (rom_addr !== 8'h00) begin
      n_fail++; $display("FAIL reset_pc: got %0h expected 0", rom_addr);
    end
    n_checks++;
    if (ir !== 8'h00) begin
      n_fail++; $display("FAIL reset_ir: got %0h expected 0", ir);
    end
    n_checks++;
    if (instr_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", instr_count);
    end
    n_checks++;
    if ({exec, halted, step_ack} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {exec, halted, step_ack});
    end
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    logic [7:0]  exp_pc    [5] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03};
    logic [7:0]  exp_ir    [5] = '{8'h00, 8'h20, 8'h20, 8'h31, 8'h31};
    logic        exp_exec  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] exp_cnt   [5] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2};
    clear_rom();
    rom[0] = 8'h20;
    rom[1] = 8'h31;
    rom[2] = 8'h05;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k != 0) tick();
      n_checks++;
      if (rom_addr !== exp_pc[k]) begin
        n_fail++; $display("FAIL run_pc[%0d]: got %0h expected %0h", k, rom_addr, exp_pc[k]);
      end
      n_checks++;
      if (ir !== exp_ir[k]) begin
        n_fail++; $display("FAIL run_ir[%0d]: got %0h expected %0h", k, ir, exp_ir[k]);
      end
      n_checks++;
      if (exec !== exp_exec[k]) begin
        n_fail++; $display("FAIL run_exec[%0d]: got %b expected %b", k, exec, exp_exec[k]);
      end
      n_checks++;
      if (instr_count !== exp_cnt[k]) begin
        n_fail++;
        $display("FAIL run_cnt[%0d]: got %0d expected %0d", k, instr_count, exp_cnt[k]);
      end
    end
  endtask

  task automatic test_jump();
    clear_rom();
    rom[4] = 8'h71;
    rom[5] = 8'h99;
    do_reset();
    repeat (8) tick();
    n_checks++;
    if (rom_addr !== 8'h04) begin
      n_fail++; $display("FAIL jump_pre_pc: got %0h expected 04", rom_addr);
    end
    tick();
    n_checks++;
    if (ir !== 8'h71 || exec !== 1'b1) begin
      n_fail++; $display("FAIL jump_ir: got %0h/%b expected 71/1", ir, exec);
    end
    do_jump_bar = 1'b0;
    bus_data    = 8'h10;
    tick();
    do_jump_bar = 1'b1;
    n_checks++;
    if (rom_addr !== 8'h10) begin
      n_fail++; $display("FAIL jump_target: got %0h expected 10", rom_addr);
    end
    n_checks++;
    if (instr_count !== 16'd5) begin
      n_fail++; $display("FAIL jump_count: got %0d expected 5", instr_count);
    end
    n_checks++;
    if (halted !== 1'b0 || exec !== 1'b0) begin
      n_fail++; $display("FAIL jump_state: got %b%b expected 00", halted, exec);
    end
  endtask

  task automatic test_halt();
    clear_rom();
    rom[8] = 8'h71;
    do_reset();
    repeat (17) tick();
    n_checks++;
    if (ir !== 8'h71 || rom_addr !== 8'h09) begin
      n_fail++; $display("FAIL halt_pre: got ir %0h pc %0h expected 71/09", ir, rom_addr);
    end
    do_jump_bar = 1'b0;
    bus_data    = 8'h08;
    tick();
    do_jump_bar = 1'b1;
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (halted !== 1'b1 || exec !== 1'b0 || step_ack !== 1'b0 || rom_addr !== 8'h08 ||
          ir !== 8'h71 || instr_count !== 16'd9) begin
        n_fail++;
        $display("FAIL halt_frozen[%0d]: got h%b e%b a%b pc %0h ir %0h cnt %0d expected 1 0 0 08 71 9",
                 c, halted, exec, step_ack, rom_addr, ir, instr_count);
      end
      step_req  = ~step_req;
      step_mode = c[1];
      tick();
    end
    step_req  = 1'b0;
    step_mode = 1'b0;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    n_checks++;
    if (rom_addr !== 8'h00 || halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_reset: got pc %0h h%b expected 00 0", rom_addr, halted);
    end
  endtask

  task automatic test_step();
    logic        exp_ack  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        exp_exec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int          acks;
    clear_rom();
    step_mode = 1'b1;
    step_req  = 1'b0;
    do_reset();
    tick();
    tick();
    for (int w = 0; w < 3; w++) begin
      n_checks++;
      if (exec !== 1'b0 || rom_addr !== 8'h01 || instr_count !== 16'd1 || step_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL step_wait[%0d]: got e%b pc %0h cnt %0d a%b expected 0 01 1 0",
                 w, exec, rom_addr, instr_count, step_ack);
      end
      tick();
    end
    acks = 0;
    step_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (step_ack === 1'b1) acks++;
      n_checks++;
      if (step_ack !== exp_ack[k] || exec !== exp_exec[k]) begin
        n_fail++;
        $display("FAIL step_seq[%0d]: got a%b e%b expected a%b e%b",
                 k, step_ack, exec, exp_ack[k], exp_exec[k]);
      end
    end
    step_req = 1'b0;
    tick();
    n_checks++;
    if (acks != 2 || instr_count !== 16'd3) begin
      n_fail++; $display("FAIL step_count: got acks %0d cnt %0d expected 2 3", acks, instr_count);
    end
    tick();
    n_checks++;
    if (exec !== 1'b0 || instr_count !== 16'd3) begin
      n_fail++; $display("FAIL step_park: got e%b cnt %0d expected 0 3", exec, instr_count);
    end
    step_mode = 1'b0;
    tick();
    n_checks++;
    if (step_ack !== 1'b0 || exec !== 1'b0) begin
      n_fail++; $display("FAIL step_release: got a%b e%b expected 0 0", step_ack, exec);
    end
    tick();
    tick();
    n_checks++;
    if (instr_count !== 16'd4 || exec !== 1'b0 || rom_addr !== 8'h04) begin
      n_fail++;
      $display("FAIL step_freerun: got cnt %0d e%b pc %0h expected 4 0 04",
               instr_count, exec, rom_addr);
    end
  endtask

  task automatic test_reset_mid_exec();
    clear_rom();
    rom[1] = 8'h71;
    do_reset();
    repeat (3) tick();
    n_checks++;
    if (exec !== 1'b1 || ir !== 8'h71 || instr_count !== 16'd1) begin
      n_fail++; $display("FAIL rst_exec_pre: got e%b ir %0h cnt %0d expected 1 71 1",
                         exec, ir, instr_count);
    end
    do_jump_bar = 1'b0;
    bus_data    = 8'h40;
    reset       = 1'b1;
    tick();
    reset       = 1'b0;
    do_jump_bar = 1'b1;
    n_checks++;
    if (rom_addr !== 8'h00 || ir !== 8'h00 || instr_count !== 16'd0 || exec !== 1'b0 ||
        halted !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_exec: got pc %0h ir %0h cnt %0d e%b h%b expected 00 00 0 0 0",
               rom_addr, ir, instr_count, exec, halted);
    end
  endtask

  task automatic test_pc_wrap();
    clear_rom();
    rom[0]    = 8'h71;
    rom[8'hFE] = 8'h31;
    do_reset();
    tick();
    do_jump_bar = 1'b0;
    bus_data    = 8'hFE;
    tick();
    do_jump_bar = 1'b1;
    n_checks++;
    if (rom_addr !== 8'hFE) begin
      n_fail++; $display("FAIL wrap_pc_fe: got %0h expected fe", rom_addr);
    end
    tick();
    n_checks++;
    if (rom_addr !== 8'hFF || ir !== 8'h31) begin
      n_fail++; $display("FAIL wrap_pc_ff: got pc %0h ir %0h expected ff 31", rom_addr, ir);
    end
    tick();
    n_checks++;
    if (rom_addr !== 8'h00 || instr_count !== 16'd2) begin
      n_fail++; $display("FAIL wrap_pc_00: got pc %0h cnt %0d expected 00 2",
                         rom_addr, instr_count);
    end
    tick();
    n_checks++;
    if (ir !== 8'h71 || exec !== 1'b1 || rom_addr !== 8'h01) begin
      n_fail++; $display("FAIL wrap_fetch0: got ir %0h e%b pc %0h expected 71 1 01",
                         ir, exec, rom_addr);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    bus_data    = 8'h00;
    do_jump_bar = 1'b1;
    step_mode   = 1'b0;
    step_req    = 1'b0;
    clear_rom();
    tick();
    test_reset();
    test_free_run();
    test_jump();
    test_halt();
    test_step();
    test_reset_mid_exec();
    test_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nic8_sequencer.md
Name: nic8_sequencer

Overview:
Fetch/execute sequencer for the nic8 CPU. Owns the program counter and the instruction register, and presents the IR to the instruction decoder. It alternates FETCH and EXEC phases, steps the PC over immediate operands, and applies taken jumps. It also provides halt detection (jump-to-self) and a single-step handshake for the debug front panel.

Parameters:
ADDR_W, 8, width of PC and ROM address
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
romData  input  8  ROM read data at address romAddr
busData  input  8  datapath bus value; jump target during EXEC
doJumpBar  input  1  from decoder, low = jump taken this EXEC
stepMode  input  1  1 = pause in WAIT after every instruction
stepReq  input  1  level request to run one instruction from WAIT
romAddr  output  ADDR_W  ROM address, equal to pc
ir  output  8  instruction register, drives decoder
exec  output  1  high only in EXEC; qualifies all register triggers/stores
halted  output  1  high in HALT
stepAck  output  1  one-cycle pulse when leaving WAIT
instrCount  output  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, EXEC, WAIT, HALT. Encoding is implementation choice.
- Reset (reset=1 at edge, in any state and mid-instruction): state=FETCH, pc=RESET_PC, ir=0x00, instrAddr=RESET_PC, instrCount=0, stepAck=0, halted=0, exec=0. Reset has priority over every other input.
- ir=0x00 decodes as a no-op load (dest 0). This makes the pre-fetch decode harmless.
- FETCH (1 cycle):
  - ir<=romData; instrAddr<=pc; pc<=pc+1 (wraps modulo 2^ADDR_W).
  - Next state is EXEC.
- EXEC (1 cycle), exec=1, decoder operates on ir, romAddr=pc supplies the immediate:
  - If doJumpBar=0: pc<=busData[ADDR_W-1:0]. The jump wins over the immediate increment.
  - Else if ir[2:0]==3'b001 (ROM source): pc<=pc+1 (wraps).
  - Else pc is unchanged.
  - instrCount<=instrCount+1 (wraps).
  - Next state, in priority order:
    - HALT if doJumpBar=0 and busData==instrAddr.
    - Else WAIT if stepMode=1.
    - Else FETCH.
- WAIT:
  - exec=0; pc and ir are held.
  - When stepReq=1: go to FETCH and assert stepAck for that one cycle.
  - If stepMode drops to 0 while in WAIT: go to FETCH, with no stepAck.
  - A stepReq held high gives exactly one instruction per WAIT visit.
- HALT:
  - exec=0, halted=1. pc, ir and instrCount are frozen.
  - Only reset exits HALT. stepReq and stepMode are ignored.
- Latency: one instruction takes 2 cycles, plus the time spent in WAIT.
- romAddr is combinational from pc. No other output depends combinationally on any input.

Optional Feature:
Macro SEQ_BREAKPOINT_EN.
- Defined:
  - Adds ports breakAddr (input, ADDR_W) and breakEn (input, 1).
  - In FETCH, if breakEn=1 and pc==breakAddr, the fetch still completes normally.
  - After the following EXEC, the sequencer enters WAIT regardless of stepMode.
  - Halt takes priority over the breakpoint.
- Undefined: these ports do not exist, and the behaviour is exactly as above.

Test Plan:
- Reset then free-run with ROM = 0x20,0x31,0x05 (A<=0; B<=imm 5): ir sequence 0x20, 0x31; pc sequence 0→1→1→2→3; exec high on cycles 2 and 4; instrCount=2.
- Jump: ir=0x71 at address 0x04, doJumpBar=0, busData=0x10 → next romAddr=0x10, not 0x06; instrCount increments.
- Halt: ir=0x71 at 0x08, doJumpBar=0, busData=0x08 → halted=1 from the next cycle; pc, ir and count frozen for 20 cycles while stepReq toggles; reset → pc=0, halted=0.
- Step mode: stepMode=1 → WAIT after each EXEC; stepReq held high for 5 cycles → exactly one stepAck pulse and one instruction per WAIT visit.
- Reset asserted during EXEC of a taken jump → pc=RESET_PC, ir=0x00, no count increment.
- PC wrap: instruction with immediate at 0xFE → pc moves 0xFE→0xFF→0x00, next fetch from 0x00.
